// File: rtl/e1_tx_hdb3_pkg.sv
// Shared types for the E1 HDB3 transmit path: line symbols, pulse polarity and pipe depth.
package e1_tx_hdb3_pkg;

   typedef enum logic [1:0] {
      SYM_ZERO = 2'd0,
      SYM_MARK = 2'd1,
      SYM_B    = 2'd2,
      SYM_V    = 2'd3
   } sym_t;

   typedef enum logic {
      POL_POS = 1'b0,
      POL_NEG = 1'b1
   } pol_t;

   localparam int PIPE_DEPTH        = 4;
   localparam int DEFAULT_PULSE_LEN = 7;

   function automatic pol_t flip_pol(input pol_t p);
      return (p == POL_POS) ? POL_NEG : POL_POS;
   endfunction

endpackage

// File: rtl/e1_tx_hdb3_if.sv
// Framer-to-encoder bit stream plus the pad-side pulse requests.
// cfg_ami exists only when E1_TX_AMI_EN is defined.
interface e1_tx_hdb3_if;

   logic in_data;
   logic in_stb;
`ifdef E1_TX_AMI_EN
   logic cfg_ami;
`endif
   logic tx_hi;
   logic tx_lo;

`ifdef E1_TX_AMI_EN
   modport master (output in_data, output in_stb, output cfg_ami, input tx_hi, input tx_lo);
   modport slave  (input in_data, input in_stb, input cfg_ami, output tx_hi, output tx_lo);
`else
   modport master (output in_data, output in_stb, input tx_hi, input tx_lo);
   modport slave  (input in_data, input in_stb, output tx_hi, output tx_lo);
`endif

endinterface

// File: rtl/e1_tx_pulse.sv
// Pulse shaper: turns one line symbol per strobe into a PULSE_LEN-clock RZ pulse on tx_hi/tx_lo,
// tracking the polarity of the last transmitted mark.
module e1_tx_pulse
   import e1_tx_hdb3_pkg::*;
#(
   parameter int PULSE_LEN = DEFAULT_PULSE_LEN
)
(
   input  logic clk,
   input  logic rst,
   input  sym_t sym,
   input  logic sym_valid,
   output logic tx_hi,
   output logic tx_lo
);

   localparam int             CNT_W    = $clog2(PULSE_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

   pol_t             last_pol_q;
   pol_t             last_pol_d;
   pol_t             pulse_pol;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             tx_hi_q;
   logic             tx_hi_d;
   logic             tx_lo_q;
   logic             tx_lo_d;

   // A new symbol always cuts off whatever pulse is still running; V reuses the last polarity.
   always_comb begin
      last_pol_d = last_pol_q;
      cnt_d      = cnt_q;
      tx_hi_d    = tx_hi_q;
      tx_lo_d    = tx_lo_q;
      pulse_pol  = last_pol_q;
      if (sym_valid) begin
         tx_hi_d = 1'b0;
         tx_lo_d = 1'b0;
         cnt_d   = '0;
         unique case (sym)
            SYM_MARK, SYM_B: begin
               pulse_pol  = flip_pol(last_pol_q);
               last_pol_d = pulse_pol;
            end
            SYM_V:   pulse_pol = last_pol_q;
            default: pulse_pol = last_pol_q;
         endcase
         if (sym != SYM_ZERO) begin
            tx_hi_d = (pulse_pol == POL_POS);
            tx_lo_d = (pulse_pol == POL_NEG);
            cnt_d   = CNT_LOAD;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         tx_hi_d = 1'b0;
         tx_lo_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_pol_q <= POL_NEG;
         cnt_q      <= '0;
         tx_hi_q    <= 1'b0;
         tx_lo_q    <= 1'b0;
      end else begin
         last_pol_q <= last_pol_d;
         cnt_q      <= cnt_d;
         tx_hi_q    <= tx_hi_d;
         tx_lo_q    <= tx_lo_d;
      end
   end

   assign tx_hi = tx_hi_q;
   assign tx_lo = tx_lo_q;

endmodule

// File: rtl/e1_tx_hdb3.sv
// E1 HDB3 line encoder: 4-symbol pipe with zero-run substitution feeding the pulse shaper.
// Define E1_TX_AMI_EN to add cfg_ami, which disables substitution (plain AMI).
module e1_tx_hdb3
   import e1_tx_hdb3_pkg::*;
#(
   parameter int PULSE_LEN = DEFAULT_PULSE_LEN
)
(
   input  logic         clk,
   input  logic         rst,
   e1_tx_hdb3_if.slave  bus
);

   sym_t pipe_q [PIPE_DEPTH];
   sym_t pipe_d [PIPE_DEPTH];
   logic ones_par_q;
   logic ones_par_d;
   logic subst_en;
   logic zero_window;
   logic tx_hi_w;
   logic tx_lo_w;

`ifdef E1_TX_AMI_EN
   assign subst_en = ~bus.cfg_ami;
`else
   assign subst_en = 1'b1;
`endif

   // B and V are never SYM_ZERO, so already-substituted entries drop out of the window by themselves.
   assign zero_window = ~bus.in_data
                        && (pipe_q[0] == SYM_ZERO)
                        && (pipe_q[1] == SYM_ZERO)
                        && (pipe_q[2] == SYM_ZERO);

   always_comb begin
      pipe_d     = pipe_q;
      ones_par_d = ones_par_q;
      if (bus.in_stb) begin
         pipe_d[0] = bus.in_data ? SYM_MARK : SYM_ZERO;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
         end
         if (bus.in_data) begin
            ones_par_d = ~ones_par_q;
         end
         if (zero_window && subst_en) begin
            pipe_d[0] = SYM_V;
            if (!ones_par_q) begin
               pipe_d[PIPE_DEPTH-1] = SYM_B;
            end
            ones_par_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            pipe_q[i] <= SYM_ZERO;
         end
         ones_par_q <= 1'b0;
      end else begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
         ones_par_q <= ones_par_d;
      end
   end

   // The symbol shifted out of the oldest slot is what goes to the line on this strobe.
   e1_tx_pulse #(
      .PULSE_LEN (PULSE_LEN)
   ) u_pulse (
      .clk       (clk),
      .rst       (rst),
      .sym       (pipe_q[PIPE_DEPTH-1]),
      .sym_valid (bus.in_stb),
      .tx_hi     (tx_hi_w),
      .tx_lo     (tx_lo_w)
   );

   assign bus.tx_hi = tx_hi_w;
   assign bus.tx_lo = tx_lo_w;

endmodule

// File: tb/tb_e1_tx_hdb3.sv
// Self-checking bench for e1_tx_hdb3: an in-order HDB3 reference model fills a queue of expected
// line symbols, and each strobe's observed pulse shape is compared against the popped entry.
module tb_e1_tx_hdb3;

   localparam int PULSE_LEN = 7;
   localparam int BIT_CLKS  = 15;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   // Reference model state: line value per stream position (+1, -1, 0).
   int   exp_q [$];
   int   m_run;
   int   m_last;
   bit   m_par;
   bit   m_ami;

   e1_tx_hdb3_if bus ();

   e1_tx_hdb3 #(
      .PULSE_LEN (PULSE_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset leaves four ZERO slots; the newest three already count towards a zero run.
   task automatic model_reset();
      exp_q  = {};
      for (int i = 0; i < 4; i++) exp_q.push_back(0);
      m_run  = 3;
      m_last = -1;
      m_par  = 1'b0;
   endtask

   task automatic model_push(input bit d);
      if (d) begin
         m_last = -m_last;
         exp_q.push_back(m_last);
         m_par = ~m_par;
         m_run = 0;
      end else begin
         m_run++;
         if (m_run >= 4 && !m_ami) begin
            if (!m_par) begin
               m_last = -m_last;
               exp_q[exp_q.size()-3] = m_last;
            end
            exp_q.push_back(m_last);
            m_par = 1'b0;
            m_run = 0;
         end else begin
            exp_q.push_back(0);
         end
      end
   endtask

   function automatic logic [63:0] exp_vec(input int line, input int want, input int gap);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < gap && k < PULSE_LEN; k++) begin
         if (line == want) v[k] = 1'b1;
      end
      return v;
   endfunction

   // Called at a negedge; returns at the negedge just before the next strobe slot.
   task automatic drive_bit(input bit d, input int gap, output logic [63:0] hi_v,
                            output logic [63:0] lo_v, output int exp_line);
      bus.in_data = d;
      bus.in_stb  = 1'b1;
      model_push(d);
      exp_line = exp_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      bus.in_stb = 1'b0;
      hi_v = '0;
      lo_v = '0;
      for (int k = 0; k < gap; k++) begin
         hi_v[k] = bus.tx_hi;
         lo_v[k] = bus.tx_lo;
         if (k < gap - 1) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.in_stb  = 1'b0;
      bus.in_data = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.in_stb  = 1'b0;
      bus.in_data = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({bus.tx_hi, bus.tx_lo} !== 2'b00) begin
         n_miss++;
         $display("[TB] FAIL reset_outputs: tx_hi/tx_lo=%b, expected 00", {bus.tx_hi, bus.tx_lo});
      end
      do_reset();
   endtask

   task automatic test_seq(input string name, input bit seq [$], input int gap);
      logic [63:0] hi_v;
      logic [63:0] lo_v;
      int          e;
      do_reset();
      foreach (seq[i]) begin
         drive_bit(seq[i], gap, hi_v, lo_v, e);
         n_vec++;
         if (hi_v !== exp_vec(e, 1, gap) || lo_v !== exp_vec(e, -1, gap)) begin
            n_miss++;
            $display("[TB] FAIL %s strobe%0d: tx_hi=%h tx_lo=%h, expected tx_hi=%h tx_lo=%h",
                     name, i + 1, hi_v, lo_v, exp_vec(e, 1, gap), exp_vec(e, -1, gap));
         end
      end
   endtask

   task automatic test_marks();
      test_seq("marks", '{1, 1, 1, 1, 0, 0, 0, 0}, BIT_CLKS);
   endtask

   task automatic test_000v();
      test_seq("sub_000v", '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0}, BIT_CLKS);
   endtask

   task automatic test_b00v();
      test_seq("sub_b00v", '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0}, BIT_CLKS);
   endtask

   task automatic test_back_to_back();
      test_seq("back_to_back", '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0}, 3);
   endtask

   task automatic test_hold();
      test_seq("hold", '{1, 1, 0, 1, 0, 0}, 40);
   endtask

   task automatic test_zero_run();
      logic [63:0] hi_v;
      logic [63:0] lo_v;
      int          e;
      int          sum;
      sum = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive_bit(1'b0, BIT_CLKS, hi_v, lo_v, e);
         sum += (hi_v[0] ? 1 : 0) - (lo_v[0] ? 1 : 0);
         n_vec++;
         if (hi_v !== exp_vec(e, 1, BIT_CLKS) || lo_v !== exp_vec(e, -1, BIT_CLKS)) begin
            n_miss++;
            $display("[TB] FAIL zero_run strobe%0d: tx_hi=%h tx_lo=%h, expected tx_hi=%h tx_lo=%h",
                     i + 1, hi_v, lo_v, exp_vec(e, 1, BIT_CLKS), exp_vec(e, -1, BIT_CLKS));
         end
      end
      n_vec++;
      if (sum > 1 || sum < -1) begin
         n_miss++;
         $display("[TB] FAIL zero_run_dc: polarity sum=%0d, expected within -1..1", sum);
      end
   endtask

   task automatic test_rst_mid_pulse();
      logic [63:0] hi_v;
      logic [63:0] lo_v;
      int          e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_bit(i == 0, BIT_CLKS, hi_v, lo_v, e);
      end
      bus.in_data = 1'b0;
      bus.in_stb  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_stb = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if ({bus.tx_hi, bus.tx_lo} !== 2'b10) begin
         n_miss++;
         $display("[TB] FAIL rst_mid_pulse_pre: tx_hi/tx_lo=%b, expected 10", {bus.tx_hi, bus.tx_lo});
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({bus.tx_hi, bus.tx_lo} !== 2'b00) begin
         n_miss++;
         $display("[TB] FAIL rst_mid_pulse_drop: tx_hi/tx_lo=%b, expected 00", {bus.tx_hi, bus.tx_lo});
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         drive_bit(i == 0, BIT_CLKS, hi_v, lo_v, e);
         n_vec++;
         if (hi_v !== exp_vec(e, 1, BIT_CLKS) || lo_v !== exp_vec(e, -1, BIT_CLKS)) begin
            n_miss++;
            $display("[TB] FAIL rst_mid_pulse_after strobe%0d: tx_hi=%h tx_lo=%h, expected tx_hi=%h tx_lo=%h",
                     i + 1, hi_v, lo_v, exp_vec(e, 1, BIT_CLKS), exp_vec(e, -1, BIT_CLKS));
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] hi_v;
      logic [63:0] lo_v;
      int          e;
      int          g;
      bit          d;
      do_reset();
      for (int i = 0; i < 48; i++) begin
         d = ($urandom_range(0, 2) == 0);
         g = $urandom_range(8, BIT_CLKS);
         drive_bit(d, g, hi_v, lo_v, e);
         n_vec++;
         if (hi_v !== exp_vec(e, 1, g) || lo_v !== exp_vec(e, -1, g)) begin
            n_miss++;
            $display("[TB] FAIL random strobe%0d: tx_hi=%h tx_lo=%h, expected tx_hi=%h tx_lo=%h",
                     i + 1, hi_v, lo_v, exp_vec(e, 1, g), exp_vec(e, -1, g));
         end
      end
   endtask

`ifdef E1_TX_AMI_EN
   task automatic test_ami();
      bus.cfg_ami = 1'b1;
      m_ami       = 1'b1;
      test_seq("ami", '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0}, BIT_CLKS);
      bus.cfg_ami = 1'b0;
      m_ami       = 1'b0;
   endtask
`endif

   initial begin
      n_vec       = 0;
      n_miss      = 0;
      m_ami       = 1'b0;
      rst         = 1'b1;
      bus.in_data = 1'b0;
      bus.in_stb  = 1'b0;
`ifdef E1_TX_AMI_EN
      bus.cfg_ami = 1'b0;
`endif
      model_reset();
      @(negedge clk);
      test_reset();
      test_marks();
      test_000v();
      test_b00v();
      test_zero_run();
      test_rst_mid_pulse();
      test_back_to_back();
      test_hold();
      test_random();
`ifdef E1_TX_AMI_EN
      test_ami();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
